// File: rtl/anycore_l15_resp_encoder_pkg.sv
// Shared constants for the AnyCore L1.5 response encoder: iop.h request and return types,
// the boot/run state encoding, and the 64-bit byte-swap helper.
package anycore_l15_resp_encoder_pkg;

  localparam int PHY_ADDR_WIDTH = 40;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] IMISS_RQ = 5'b10000;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } boot_state_e;

  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/anycore_resp_pending_tracker.sv
// Per-type outstanding-request flags and captured addresses for imiss, load and store.
module anycore_resp_pending_tracker
  import anycore_l15_resp_encoder_pkg::*;
#(
  parameter int ADDR_W = PHY_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_imiss,
  input  logic              cap_load,
  input  logic              cap_store,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic              clr_imiss,
  input  logic              clr_load,
  input  logic              clr_store,
  output logic              pend_imiss,
  output logic              pend_load,
  output logic              pend_store,
  output logic [ADDR_W-1:0] imiss_addr,
  output logic [ADDR_W-1:0] load_addr,
  output logic              cap_err
);

  // A capture coinciding with the clear of the same type re-arms the flag and is legal.
  assign cap_err = (cap_imiss & pend_imiss & ~clr_imiss) |
                   (cap_load  & pend_load  & ~clr_load)  |
                   (cap_store & pend_store & ~clr_store);

  // The store return carries no address, so only the flag is kept for stores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_imiss <= 1'b0;
      pend_load  <= 1'b0;
      pend_store <= 1'b0;
      imiss_addr <= '0;
      load_addr  <= '0;
    end else begin
      pend_imiss <= cap_imiss | (pend_imiss & ~clr_imiss);
      pend_load  <= cap_load  | (pend_load  & ~clr_load);
      pend_store <= cap_store | (pend_store & ~clr_store);
      if (cap_imiss) imiss_addr <= cap_addr;
      if (cap_load)  load_addr  <= cap_addr;
    end
  end

endmodule

// File: rtl/anycore_l15_resp_encoder.sv
// Converts L1.5 return packets into AnyCore mem2ic/mem2dc response strobes and gates core start.
// Define ANYCORE_RESP_BYTESWAP_EN to byte-reverse each 64-bit payload word.
module anycore_l15_resp_encoder
  import anycore_l15_resp_encoder_pkg::*;
#(
  parameter int IC_LINE_BITS           = 256,
  parameter int DC_LINE_BITS           = 128,
  parameter int IC_OFFSET_BITS         = 5,
  parameter int DC_OFFSET_BITS         = 4,
  parameter int ICACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - IC_OFFSET_BITS,
  parameter int DCACHE_BLOCK_ADDR_BITS = PHY_ADDR_WIDTH - DC_OFFSET_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              dec_l15_val,
  input  logic [4:0]                        dec_l15_rqtype,
  input  logic [PHY_ADDR_WIDTH-1:0]         dec_l15_address,
  input  logic                              l15_transducer_ack,
  input  logic                              l15_transducer_val,
  input  logic [3:0]                        l15_transducer_returntype,
  input  logic [63:0]                       l15_transducer_data_0,
  input  logic [63:0]                       l15_transducer_data_1,
  input  logic [63:0]                       l15_transducer_data_2,
  input  logic [63:0]                       l15_transducer_data_3,
  input  logic [11:0]                       l15_transducer_inval_address_15_4,
  input  logic                              l15_transducer_inval_dcache_all_way,
  output logic                              transducer_l15_req_ack,
  output logic                              mem2ic_respvalid,
  output logic [ICACHE_BLOCK_ADDR_BITS-1:0] mem2ic_respaddr,
  output logic [IC_LINE_BITS-1:0]           mem2ic_data,
  output logic                              mem2dc_ldvalid,
  output logic [DCACHE_BLOCK_ADDR_BITS-1:0] mem2dc_ldaddr,
  output logic [DC_LINE_BITS-1:0]           mem2dc_lddata,
  output logic                              mem2dc_stcomplete,
  output logic                              mem2dc_invvalid,
  output logic [11:0]                       mem2dc_invaddr,
  output logic                              core_run,
  output logic                              resp_err
);

  function automatic logic [63:0] word_fix(input logic [63:0] w);
`ifdef ANYCORE_RESP_BYTESWAP_EN
    return bswap64(w);
`else
    return w;
`endif
  endfunction

  boot_state_e state, state_nx;

  logic cap_imiss, cap_load, cap_store, cap_err;
  logic clr_imiss, clr_load, clr_store;
  logic pend_imiss, pend_load, pend_store;
  logic [PHY_ADDR_WIDTH-1:0] imiss_addr, load_addr;
  logic ic_fire, ld_fire, st_fire, inv_fire, ret_err;
  logic snoop;

  assign transducer_l15_req_ack = l15_transducer_val;
  assign core_run               = (state == RUN);

  assign snoop     = dec_l15_val & l15_transducer_ack;
  assign cap_imiss = snoop & (dec_l15_rqtype == IMISS_RQ);
  assign cap_load  = snoop & (dec_l15_rqtype == LOAD_RQ);
  assign cap_store = snoop & (dec_l15_rqtype == STORE_RQ);

  anycore_resp_pending_tracker #(
    .ADDR_W(PHY_ADDR_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_imiss (cap_imiss),
    .cap_load  (cap_load),
    .cap_store (cap_store),
    .cap_addr  (dec_l15_address),
    .clr_imiss (clr_imiss),
    .clr_load  (clr_load),
    .clr_store (clr_store),
    .pend_imiss(pend_imiss),
    .pend_load (pend_load),
    .pend_store(pend_store),
    .imiss_addr(imiss_addr),
    .load_addr (load_addr),
    .cap_err   (cap_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clr_imiss = 1'b0;
    clr_load  = 1'b0;
    clr_store = 1'b0;
    ic_fire   = 1'b0;
    ld_fire   = 1'b0;
    st_fire   = 1'b0;
    inv_fire  = 1'b0;
    ret_err   = 1'b0;
    if (l15_transducer_val) begin
      unique case (state)
        BOOT: begin
          if (l15_transducer_returntype == INT_RET) state_nx = RUN;
          else                                      ret_err  = 1'b1;
        end
        RUN: begin
          case (l15_transducer_returntype)
            IFILL_RET: begin
              ic_fire   = pend_imiss;
              clr_imiss = pend_imiss;
              ret_err   = ~pend_imiss;
            end
            LOAD_RET: begin
              ld_fire  = pend_load;
              clr_load = pend_load;
              ret_err  = ~pend_load;
            end
            ST_ACK: begin
              st_fire   = pend_store;
              clr_store = pend_store;
              ret_err   = ~pend_store;
            end
            EVICT_REQ: inv_fire = 1'b1;
            INT_RET:   ;
            default:   ret_err = 1'b1;
          endcase
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem2ic_respvalid  <= 1'b0;
      mem2ic_respaddr   <= '0;
      mem2ic_data       <= '0;
      mem2dc_ldvalid    <= 1'b0;
      mem2dc_ldaddr     <= '0;
      mem2dc_lddata     <= '0;
      mem2dc_stcomplete <= 1'b0;
      mem2dc_invvalid   <= 1'b0;
      mem2dc_invaddr    <= '0;
      resp_err          <= 1'b0;
    end else begin
      mem2ic_respvalid  <= ic_fire;
      mem2dc_ldvalid    <= ld_fire;
      mem2dc_stcomplete <= st_fire;
      mem2dc_invvalid   <= inv_fire;
      resp_err          <= resp_err | ret_err | cap_err;
      if (ic_fire) begin
        mem2ic_respaddr <= ICACHE_BLOCK_ADDR_BITS'(imiss_addr >> IC_OFFSET_BITS);
        mem2ic_data     <= IC_LINE_BITS'({word_fix(l15_transducer_data_3),
                                          word_fix(l15_transducer_data_2),
                                          word_fix(l15_transducer_data_1),
                                          word_fix(l15_transducer_data_0)});
      end
      if (ld_fire) begin
        mem2dc_ldaddr <= DCACHE_BLOCK_ADDR_BITS'(load_addr >> DC_OFFSET_BITS);
        mem2dc_lddata <= DC_LINE_BITS'({word_fix(l15_transducer_data_1),
                                        word_fix(l15_transducer_data_0)});
      end
      if (inv_fire) begin
        mem2dc_invaddr <= l15_transducer_inval_dcache_all_way ? '1
                                                              : l15_transducer_inval_address_15_4;
      end
    end
  end

endmodule

// File: tb/tb_anycore_l15_resp_encoder.sv
// Directed self-checking bench for anycore_l15_resp_encoder.
module tb_anycore_l15_resp_encoder;

  logic         clk;
  logic         rst_n;
  logic         dec_l15_val;
  logic [4:0]   dec_l15_rqtype;
  logic [39:0]  dec_l15_address;
  logic         l15_transducer_ack;
  logic         l15_transducer_val;
  logic [3:0]   l15_transducer_returntype;
  logic [63:0]  d0, d1, d2, d3;
  logic [11:0]  inval_addr;
  logic         inval_all;
  logic         transducer_l15_req_ack;
  logic         mem2ic_respvalid;
  logic [34:0]  mem2ic_respaddr;
  logic [255:0] mem2ic_data;
  logic         mem2dc_ldvalid;
  logic [35:0]  mem2dc_ldaddr;
  logic [127:0] mem2dc_lddata;
  logic         mem2dc_stcomplete;
  logic         mem2dc_invvalid;
  logic [11:0]  mem2dc_invaddr;
  logic         core_run;
  logic         resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] T_LOAD_RQ  = 5'b00000;
  localparam logic [4:0] T_STORE_RQ = 5'b00001;
  localparam logic [4:0] T_IMISS_RQ = 5'b10000;
  localparam logic [3:0] T_LOAD  = 4'b0000;
  localparam logic [3:0] T_IFILL = 4'b0001;
  localparam logic [3:0] T_EVICT = 4'b0011;
  localparam logic [3:0] T_STACK = 4'b0100;
  localparam logic [3:0] T_INT   = 4'b0111;

  anycore_l15_resp_encoder dut (
    .clk                                (clk),
    .rst_n                              (rst_n),
    .dec_l15_val                        (dec_l15_val),
    .dec_l15_rqtype                     (dec_l15_rqtype),
    .dec_l15_address                    (dec_l15_address),
    .l15_transducer_ack                 (l15_transducer_ack),
    .l15_transducer_val                 (l15_transducer_val),
    .l15_transducer_returntype          (l15_transducer_returntype),
    .l15_transducer_data_0              (d0),
    .l15_transducer_data_1              (d1),
    .l15_transducer_data_2              (d2),
    .l15_transducer_data_3              (d3),
    .l15_transducer_inval_address_15_4  (inval_addr),
    .l15_transducer_inval_dcache_all_way(inval_all),
    .transducer_l15_req_ack             (transducer_l15_req_ack),
    .mem2ic_respvalid                   (mem2ic_respvalid),
    .mem2ic_respaddr                    (mem2ic_respaddr),
    .mem2ic_data                        (mem2ic_data),
    .mem2dc_ldvalid                     (mem2dc_ldvalid),
    .mem2dc_ldaddr                      (mem2dc_ldaddr),
    .mem2dc_lddata                      (mem2dc_lddata),
    .mem2dc_stcomplete                  (mem2dc_stcomplete),
    .mem2dc_invvalid                    (mem2dc_invvalid),
    .mem2dc_invaddr                     (mem2dc_invaddr),
    .core_run                           (core_run),
    .resp_err                           (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives an optional snoop and/or return for one cycle starting at a negedge;
  // returns at the following negedge, when the registered strobes are visible.
  task automatic drive(input logic sn, input logic [4:0] rq, input logic [39:0] addr,
                       input logic rv, input logic [3:0] rt,
                       input logic [11:0] ia, input logic iall);
    @(negedge clk);
    dec_l15_val               = sn;
    l15_transducer_ack        = sn;
    dec_l15_rqtype            = rq;
    dec_l15_address           = addr;
    l15_transducer_val        = rv;
    l15_transducer_returntype = rt;
    inval_addr                = ia;
    inval_all                 = iall;
    @(negedge clk);
    dec_l15_val        = 1'b0;
    l15_transducer_ack = 1'b0;
    l15_transducer_val = 1'b0;
  endtask

  task automatic snoop(input logic [4:0] rq, input logic [39:0] addr);
    drive(1'b1, rq, addr, 1'b0, T_INT, 12'h0, 1'b0);
  endtask

  task automatic ret(input logic [3:0] rt);
    drive(1'b0, T_LOAD_RQ, 40'h0, 1'b1, rt, 12'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({mem2ic_respvalid, mem2dc_ldvalid, mem2dc_stcomplete, mem2dc_invvalid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000",
        {mem2ic_respvalid, mem2dc_ldvalid, mem2dc_stcomplete, mem2dc_invvalid}); end
    n_chk++; if ({core_run, resp_err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_run_err: got %b want 00", {core_run, resp_err}); end
    n_chk++; if (mem2ic_data !== 256'h0 || mem2dc_lddata !== 128'h0 || mem2ic_respaddr !== 35'h0 ||
                 mem2dc_ldaddr !== 36'h0 || mem2dc_invaddr !== 12'h0) begin
      n_fail++; $display("FAIL reset_data: got ic=%h ld=%h want 0", mem2ic_data, mem2dc_lddata); end
  endtask

  task automatic test_boot_gate();
    snoop(T_LOAD_RQ, 40'h0000_0040);
    d0 = 64'h5555_5555_5555_5555;
    ret(T_LOAD);
    n_chk++; if (mem2dc_ldvalid !== 1'b0) begin
      n_fail++; $display("FAIL boot_no_ldvalid: got %b want 0", mem2dc_ldvalid); end
    n_chk++; if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL boot_err: got %b want 1", resp_err); end
    n_chk++; if (core_run !== 1'b0) begin
      n_fail++; $display("FAIL boot_core_run_low: got %b want 0", core_run); end
    @(negedge clk);
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = T_INT;
    #1;
    n_chk++; if (transducer_l15_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL req_ack_comb: got %b want 1", transducer_l15_req_ack); end
    @(negedge clk);
    l15_transducer_val = 1'b0;
    n_chk++; if (core_run !== 1'b1) begin
      n_fail++; $display("FAIL boot_core_run_high: got %b want 1", core_run); end
    ret(T_INT);
    n_chk++; if (core_run !== 1'b1) begin
      n_fail++; $display("FAIL run_second_int: got %b want 1", core_run); end
  endtask

  task automatic test_ifill();
    do_reset();
    ret(T_INT);
    snoop(T_IMISS_RQ, 40'h00_0000_1240);
    d0 = 64'h1111_1111_1111_1111; d1 = 64'h2222_2222_2222_2222;
    d2 = 64'h3333_3333_3333_3333; d3 = 64'h4444_4444_4444_4444;
    ret(T_IFILL);
    n_chk++; if (mem2ic_respvalid !== 1'b1) begin
      n_fail++; $display("FAIL ifill_valid: got %b want 1", mem2ic_respvalid); end
    n_chk++; if (mem2ic_respaddr !== 35'h92) begin
      n_fail++; $display("FAIL ifill_addr: got %h want 92", mem2ic_respaddr); end
    n_chk++; if (mem2ic_data !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      n_fail++; $display("FAIL ifill_data: got %h", mem2ic_data); end
    @(negedge clk);
    n_chk++; if (mem2ic_respvalid !== 1'b0 || mem2ic_respaddr !== 35'h92) begin
      n_fail++; $display("FAIL ifill_pulse_end: got v=%b a=%h want 0/92", mem2ic_respvalid, mem2ic_respaddr); end
    n_chk++; if (resp_err !== 1'b0) begin
      n_fail++; $display("FAIL ifill_err: got %b want 0", resp_err); end
  endtask

  task automatic test_load();
    logic [127:0] exp;
    snoop(T_LOAD_RQ, 40'h00_8000_0010);
    d0 = 64'h0102_0304_0506_0708; d1 = 64'hA0A1_A2A3_A4A5_A6A7;
`ifdef ANYCORE_RESP_BYTESWAP_EN
    exp = {64'hA7A6_A5A4_A3A2_A1A0, 64'h0807_0605_0403_0201};
`else
    exp = {64'hA0A1_A2A3_A4A5_A6A7, 64'h0102_0304_0506_0708};
`endif
    ret(T_LOAD);
    n_chk++; if (mem2dc_ldvalid !== 1'b1) begin
      n_fail++; $display("FAIL load_valid: got %b want 1", mem2dc_ldvalid); end
    n_chk++; if (mem2dc_ldaddr !== 36'h8000001) begin
      n_fail++; $display("FAIL load_addr: got %h want 8000001", mem2dc_ldaddr); end
    n_chk++; if (mem2dc_lddata !== exp) begin
      n_fail++; $display("FAIL load_data: got %h want %h", mem2dc_lddata, exp); end
    @(negedge clk);
    n_chk++; if (mem2dc_ldvalid !== 1'b0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse_end: got v=%b e=%b want 0/0", mem2dc_ldvalid, resp_err); end
  endtask

  task automatic test_store_ack();
    snoop(T_STORE_RQ, 40'h00_0000_0100);
    ret(T_STACK);
    n_chk++; if (mem2dc_stcomplete !== 1'b1) begin
      n_fail++; $display("FAIL stack_pulse: got %b want 1", mem2dc_stcomplete); end
    @(negedge clk);
    n_chk++; if (mem2dc_stcomplete !== 1'b0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL stack_pulse_end: got s=%b e=%b want 0/0", mem2dc_stcomplete, resp_err); end
    ret(T_STACK);
    n_chk++; if (mem2dc_stcomplete !== 1'b0) begin
      n_fail++; $display("FAIL stack_unexpected_pulse: got %b want 0", mem2dc_stcomplete); end
    n_chk++; if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL stack_unexpected_err: got %b want 1", resp_err); end
  endtask

  task automatic test_unknown_rt();
    do_reset();
    ret(T_INT);
    ret(4'hF);
    n_chk++; if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL unknown_rt_err: got %b want 1", resp_err); end
  endtask

  task automatic test_inval();
    do_reset();
    ret(T_INT);
    snoop(T_STORE_RQ, 40'h00_0000_0200);
    drive(1'b0, T_LOAD_RQ, 40'h0, 1'b1, T_EVICT, 12'h0AB, 1'b0);
    n_chk++; if (mem2dc_invvalid !== 1'b1 || mem2dc_invaddr !== 12'h0AB) begin
      n_fail++; $display("FAIL inval_idx: got v=%b a=%h want 1/0ab", mem2dc_invvalid, mem2dc_invaddr); end
    drive(1'b0, T_LOAD_RQ, 40'h0, 1'b1, T_EVICT, 12'h0AB, 1'b1);
    n_chk++; if (mem2dc_invvalid !== 1'b1 || mem2dc_invaddr !== 12'hFFF) begin
      n_fail++; $display("FAIL inval_allway: got v=%b a=%h want 1/fff", mem2dc_invvalid, mem2dc_invaddr); end
    @(negedge clk);
    n_chk++; if (mem2dc_invvalid !== 1'b0 || mem2dc_invaddr !== 12'hFFF) begin
      n_fail++; $display("FAIL inval_hold: got v=%b a=%h want 0/fff", mem2dc_invvalid, mem2dc_invaddr); end
    ret(T_STACK);
    n_chk++; if (mem2dc_stcomplete !== 1'b1 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL inval_pending_kept: got s=%b e=%b want 1/0", mem2dc_stcomplete, resp_err); end
  endtask

  task automatic test_same_cycle_and_reset();
    snoop(T_IMISS_RQ, 40'h00_0000_1000);
    drive(1'b1, T_IMISS_RQ, 40'h00_0000_2000, 1'b1, T_IFILL, 12'h0, 1'b0);
    n_chk++; if (mem2ic_respvalid !== 1'b1 || mem2ic_respaddr !== 35'h80) begin
      n_fail++; $display("FAIL same_cycle_fill: got v=%b a=%h want 1/80", mem2ic_respvalid, mem2ic_respaddr); end
    n_chk++; if (resp_err !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_err: got %b want 0", resp_err); end
    ret(T_IFILL);
    n_chk++; if (mem2ic_respvalid !== 1'b1 || mem2ic_respaddr !== 35'h100 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_rearm: got v=%b a=%h e=%b want 1/100/0",
        mem2ic_respvalid, mem2ic_respaddr, resp_err); end
    snoop(T_IMISS_RQ, 40'h00_0000_3000);
    @(negedge clk);
    rst_n = 1'b0;
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = T_IFILL;
    @(negedge clk);
    rst_n = 1'b1;
    l15_transducer_val = 1'b0;
    n_chk++; if (mem2ic_respvalid !== 1'b0 || mem2ic_respaddr !== 35'h0 || mem2ic_data !== 256'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got v=%b a=%h want 0/0", mem2ic_respvalid, mem2ic_respaddr); end
    n_chk++; if (core_run !== 1'b0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_boot: got run=%b e=%b want 0/0", core_run, resp_err); end
    ret(T_INT);
    ret(T_IFILL);
    n_chk++; if (mem2ic_respvalid !== 1'b0 || resp_err !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pending_dropped: got v=%b e=%b want 0/1", mem2ic_respvalid, resp_err); end
  endtask

  initial begin
    rst_n = 1'b0;
    dec_l15_val = 1'b0; dec_l15_rqtype = '0; dec_l15_address = '0;
    l15_transducer_ack = 1'b0; l15_transducer_val = 1'b0;
    l15_transducer_returntype = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    inval_addr = '0; inval_all = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_boot_gate();
    test_ifill();
    test_load();
    test_store_ack();
    test_unknown_rt();
    test_inval();
    test_same_cycle_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
